// File: rtl/cla8_chain_seq.sv
// -----------------------------------------------------------------------------
// cla8_chain_seq
// Feeds an existing 8-bit carry-lookahead adder (CLA8) one byte pair at a time.
// The carry from each byte is chained into the next, so the block performs an
// NBYTES*8-bit addition. Operand and result bytes stream least-significant byte
// first.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start, cin_init     begin a new word (sampled in IDLE), with initial carry
//   in_valid/in_ready   operand byte-pair stream, in_a / in_b
//   cla_a/cla_b/cla_cin registered operands and chained carry to the CLA8
//   cla_sum/cla_cout    combinational CLA8 result
//   out_valid/out_ready result byte stream, out_sum, out_last on the MS byte
//   carry_out, ovf      final carry and signed overflow, held until next start
//   busy                high whenever the sequencer is not IDLE
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. A producer holding valid keeps its payload stable until that
// edge; ready never depends on valid. Here in_ready is high only in LOAD, and
// out_valid, once raised, stays high with stable out_sum/out_last until taken.
// -----------------------------------------------------------------------------
module cla8_chain_seq #(
  parameter int NBYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cin_init,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic [7:0] cla_a,
  output logic [7:0] cla_b,
  output logic       cla_cin,
  input  logic [7:0] cla_sum,
  input  logic       cla_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       out_last,
  output logic       carry_out,
  output logic       ovf,
  output logic       busy
);

  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CAPT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [7:0]      cla_a_q, cla_a_d;
  logic [7:0]      cla_b_q, cla_b_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_sum_q, out_sum_d;
  logic            out_last_q, out_last_d;
  logic            carry_out_q, carry_out_d;
  logic            ovf_q, ovf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cla_a_q     <= 8'h00;
      cla_b_q     <= 8'h00;
      out_valid_q <= 1'b0;
      out_sum_q   <= 8'h00;
      out_last_q  <= 1'b0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cla_a_q     <= cla_a_d;
      cla_b_q     <= cla_b_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      carry_out_q <= carry_out_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    cla_a_d     = cla_a_q;
    cla_b_d     = cla_b_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    carry_out_d = carry_out_q;
    ovf_d       = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          carry_d     = cin_init;
          idx_d       = '0;
          carry_out_d = 1'b0;
          ovf_d       = 1'b0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          cla_a_d = in_a;
          cla_b_d = in_b;
          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        // CLA8 has had a full cycle to settle on the registered operands.
        out_sum_d   = cla_sum;
        carry_d     = cla_cout;
        out_valid_d = 1'b1;
        out_last_d  = (idx_q == LAST_IDX);
        if (idx_q == LAST_IDX) begin
          carry_out_d = cla_cout;
          // Signed overflow: like-signed operands giving an opposite-signed MS byte.
          ovf_d = (cla_a_q[7] == cla_b_q[7]) && (cla_sum[7] != cla_a_q[7]);
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            out_last_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            idx_d   = idx_q + IDXW'(1);
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign cla_a     = cla_a_q;
  assign cla_b     = cla_b_q;
  assign cla_cin   = carry_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign carry_out = carry_out_q;
  assign ovf       = ovf_q;

endmodule
